mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 60 ++++++
 rtl/load_formatter.sv | 44 ++++
 rtl/mem_access_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared FUNC3 and FSM encodings for the memory access unit, its load formatter
// and the decode/forwarding units, plus the store-lane helper functions.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mau_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Stores only accept the signed-size encodings; loads reject 011 and 11x.
    function automatic logic f3_is_legal(input logic [2:0] f3, input logic is_store);
        logic ok;
        if (is_store) begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end else begin
            ok = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
        end
        return ok;
    endfunction

    function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic mis;
        case (size)
            2'b01:   mis = lo[0];
            2'b10:   mis = |lo;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] store_byte_en(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] ben;
        case (size)
            2'b00:   ben = 4'b0001 << lo;
            2'b01:   ben = lo[1] ? 4'b1100 : 4'b0011;
            2'b10:   ben = 4'b1111;
            default: ben = 4'b0000;
        endcase
        return ben;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] w;
        case (size)
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            2'b10:   w = d;
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Combinational load lane selection and sign/zero extension of a memory word.
module load_formatter
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the byte and halfword lanes addressed by the low address bits.
    always_comb begin
        byte_s = 8'h00;
        case (addr_lo)
            2'b00:   byte_s = word[7:0];
            2'b01:   byte_s = word[15:8];
            2'b10:   byte_s = word[23:16];
            2'b11:   byte_s = word[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo[1]) begin
            half_s = word[31:16];
        end else begin
            half_s = word[15:0];
        end
    end

    // Extend the selected lane to the full register width.
    always_comb begin
        data = 32'h0000_0000;
        case (func3)
            F3_B:    data = {{24{byte_s[7]}}, byte_s};
            F3_H:    data = {{16{half_s[15]}}, half_s};
            F3_W:    data = word;
            F3_BU:   data = {24'h00_0000, byte_s};
            F3_HU:   data = {16'h0000, half_s};
            default: data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: handshakes with a multi-cycle data memory,
// stalls the pipeline while busy, and reports misaligned/illegal/timeout faults.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEM_READ,
    input  logic        MEM_WRITE,
    input  logic [2:0]  FUNC3,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] REG_DATA2,
    input  logic [31:0] WB_DATA,
    input  logic        MEM_FWD_SEL,
    output logic        DM_READ,
    output logic        DM_WRITE,
    output logic [31:0] DM_ADDR,
    output logic [31:0] DM_WRITEDATA,
    output logic [3:0]  DM_BYTE_EN,
    input  logic [31:0] DM_READDATA,
    input  logic        DM_BUSYWAIT,
    output logic [31:0] READ_DATA,
    output logic        BUSYWAIT,
    output logic        MISALIGNED,
    output logic        ERROR
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mau_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [2:0]       func3_q, func3_d;
    logic             write_q, write_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       byte_en_q, byte_en_d;
    logic             dm_read_q, dm_read_d;
    logic             dm_write_q, dm_write_d;
    logic [31:0]      read_data_q, read_data_d;
    logic             misaligned_q, misaligned_d;
    logic             error_q, error_d;

    logic             access_s;
    logic             legal_s;
    logic             misal_s;
    logic             start_s;
    logic [31:0]      store_val_s;
    logic [31:0]      fmt_data_s;

    assign access_s    = MEM_READ | MEM_WRITE;
    assign legal_s     = f3_is_legal(FUNC3, MEM_WRITE);
    assign misal_s     = size_misaligned(FUNC3[1:0], ADDRESS[1:0]);
    assign start_s     = (state_q == ST_IDLE) && access_s && legal_s && !misal_s;
    assign store_val_s = MEM_FWD_SEL ? WB_DATA : REG_DATA2;

    load_formatter u_load_formatter (
        .word    (DM_READDATA),
        .func3   (func3_q),
        .addr_lo (addr_q[1:0]),
        .data    (fmt_data_s)
    );

    // Next-state, latch and registered-output logic of the access FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        func3_d      = func3_q;
        write_d      = write_q;
        wdata_d      = wdata_q;
        byte_en_d    = byte_en_q;
        dm_read_d    = dm_read_q;
        dm_write_d   = dm_write_q;
        read_data_d  = read_data_q;
        misaligned_d = 1'b0;
        error_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!access_s) begin
                    state_d = ST_IDLE;
                end else if (!legal_s) begin
                    error_d     = 1'b1;
                    read_data_d = 32'h0000_0000;
                end else if (misal_s) begin
                    misaligned_d = 1'b1;
                    read_data_d  = 32'h0000_0000;
                end else begin
                    // A store wins over a simultaneous load request.
                    state_d    = ST_REQ;
                    cnt_d      = '0;
                    addr_d     = ADDRESS;
                    func3_d    = FUNC3;
                    write_d    = MEM_WRITE;
                    wdata_d    = store_lanes(FUNC3[1:0], store_val_s);
                    byte_en_d  = MEM_WRITE ? store_byte_en(FUNC3[1:0], ADDRESS[1:0]) : 4'b0000;
                    dm_read_d  = !MEM_WRITE;
                    dm_write_d = MEM_WRITE;
                end
            end
            ST_REQ: begin
                if (!DM_BUSYWAIT) begin
                    if (!write_q) begin
                        read_data_d = fmt_data_s;
                    end else begin
                        read_data_d = read_data_q;
                    end
                    state_d    = ST_DONE;
                    dm_read_d  = 1'b0;
                    dm_write_d = 1'b0;
                    byte_en_d  = 4'b0000;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = ST_DONE;
                    dm_read_d   = 1'b0;
                    dm_write_d  = 1'b0;
                    byte_en_d   = 4'b0000;
                    read_data_d = 32'h0000_0000;
                    error_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d    = ST_IDLE;
                cnt_d      = '0;
                dm_read_d  = 1'b0;
                dm_write_d = 1'b0;
                byte_en_d  = 4'b0000;
            end
        endcase
    end

    // Pipeline stall: raised combinationally on a legal start, never during reset.
    always_comb begin
        BUSYWAIT = 1'b0;
        if (RESET) begin
            BUSYWAIT = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: BUSYWAIT = start_s;
                ST_REQ:  BUSYWAIT = 1'b1;
                ST_DONE: BUSYWAIT = 1'b0;
                default: BUSYWAIT = 1'b0;
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            addr_q       <= 32'h0000_0000;
            func3_q      <= 3'b000;
            write_q      <= 1'b0;
            wdata_q      <= 32'h0000_0000;
            byte_en_q    <= 4'b0000;
            dm_read_q    <= 1'b0;
            dm_write_q   <= 1'b0;
            read_data_q  <= 32'h0000_0000;
            misaligned_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            func3_q      <= func3_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            byte_en_q    <= byte_en_d;
            dm_read_q    <= dm_read_d;
            dm_write_q   <= dm_write_d;
            read_data_q  <= read_data_d;
            misaligned_q <= misaligned_d;
            error_q      <= error_d;
        end
    end

    assign DM_READ      = dm_read_q;
    assign DM_WRITE     = dm_write_q;
    assign DM_ADDR      = {addr_q[31:2], 2'b00};
    assign DM_WRITEDATA = wdata_q;
    assign DM_BYTE_EN   = byte_en_q;
    assign READ_DATA    = read_data_q;
    assign MISALIGNED   = misaligned_q;
    assign ERROR        = error_q;

endmodule
